// File: rtl/approx_err_pkg.sv
// Shared types, constants and helpers for the approximate-adder error monitor.
// Optional squared-error output is enabled by APPROX_ERR_MONITOR_SQERR_EN.
package approx_err_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int PIPE_DEPTH = 2;

    // Add two values and clamp the result to the all-ones value of a w-bit field.
    // Operands are carried in 64 bits, so w must not exceed 64.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        if (sum > lim) begin
            return lim[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Combinational error calculation: exact sum, signed difference, magnitude.
// Used in stage 1 of approx_err_monitor (APPROX_ERR_MONITOR_SQERR_EN has no effect here).
module approx_err_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH:0]   approx_out,
    output logic [WIDTH:0]   abs_err,
    output logic             nz
);

    localparam int SW = WIDTH + 1;

    logic [WIDTH:0]          exact;
    logic signed [WIDTH+1:0] diff;

    assign exact   = {1'b0, in1} + {1'b0, in2};
    assign diff    = $signed({1'b0, approx_out}) - $signed({1'b0, exact});
    assign abs_err = diff[WIDTH+1] ? SW'(-diff) : SW'(diff);
    assign nz      = (abs_err != '0);

endmodule

// File: rtl/approx_err_monitor.sv
// Streaming error-statistics monitor for approximate adders (2-stage pipeline).
// Define APPROX_ERR_MONITOR_SQERR_EN to add the sq_err_sum output for MSE.
module approx_err_monitor
    import approx_err_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     window_len,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [WIDTH:0]       approx_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [ACC_W-1:0]     abs_err_sum,
    output logic [WIDTH:0]       max_err
`ifdef APPROX_ERR_MONITOR_SQERR_EN
    ,
    output logic [ACC_W+WIDTH-1:0] sq_err_sum
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] win_len_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic [CNT_W-1:0] acc_cnt_inc;
    logic [1:0]       drain_cnt_q;
    logic             accept;
    logic             arm;
    logic             last_acc;

    logic [WIDTH:0]   calc_abs;
    logic             calc_nz;
    logic             s1_valid;
    logic [WIDTH:0]   s1_abs;
    logic             s1_nz;

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign accept   = in_valid && in_ready;
    assign arm      = start && ((state_q == IDLE) || (state_q == DONE));

    assign acc_cnt_inc = CNT_W'(sat_add(64'(acc_cnt_q), 64'd1, CNT_W));
    assign last_acc    = (win_len_q != '0) && (acc_cnt_inc == win_len_q);

    approx_err_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .in1       (in1),
        .in2       (in2),
        .approx_out(approx_out),
        .abs_err   (calc_abs),
        .nz        (calc_nz)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (start) state_d = RUN;
                RUN:   if (accept && last_acc) state_d = DRAIN;
                DRAIN: if (drain_cnt_q == 2'(PIPE_DEPTH - 1)) state_d = DONE;
                DONE:  if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Window length latch, accepted-sample count and drain timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_len_q   <= '0;
            acc_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else if (clear) begin
            acc_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (arm) begin
                win_len_q <= window_len;
                acc_cnt_q <= '0;
            end else if (accept) begin
                acc_cnt_q <= acc_cnt_inc;
            end
            if (state_q == DRAIN) begin
                drain_cnt_q <= drain_cnt_q + 2'd1;
            end else begin
                drain_cnt_q <= '0;
            end
        end
    end

    // Stage 1: capture per-sample error of each accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_abs   <= '0;
            s1_nz    <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s1_abs   <= '0;
            s1_nz    <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_abs <= calc_abs;
                s1_nz  <= calc_nz;
            end
        end
    end

    // Stage 2: saturating accumulation of the window statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            abs_err_sum <= '0;
            max_err     <= '0;
        end else if (clear || arm) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            abs_err_sum <= '0;
            max_err     <= '0;
        end else if (s1_valid) begin
            sample_cnt  <= CNT_W'(sat_add(64'(sample_cnt), 64'd1, CNT_W));
            err_cnt     <= CNT_W'(sat_add(64'(err_cnt), 64'(s1_nz), CNT_W));
            abs_err_sum <= ACC_W'(sat_add(64'(abs_err_sum), 64'(s1_abs), ACC_W));
            if (s1_abs > max_err) begin
                max_err <= s1_abs;
            end
        end
    end

`ifdef APPROX_ERR_MONITOR_SQERR_EN
    localparam int SQ_W = 2 * (WIDTH + 1);
    localparam int SQS_W = ACC_W + WIDTH;

    logic [SQ_W-1:0] s1_sq;

    assign s1_sq = {{(WIDTH + 1){1'b0}}, s1_abs} * {{(WIDTH + 1){1'b0}}, s1_abs};

    // Stage 2: saturating accumulation of squared error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_err_sum <= '0;
        end else if (clear || arm) begin
            sq_err_sum <= '0;
        end else if (s1_valid) begin
            sq_err_sum <= SQS_W'(sat_add(64'(sq_err_sum), 64'(s1_sq), SQS_W));
        end
    end
`endif

endmodule
